bus_master_arbiter: RTL
=======================

# bus_master_arbiter

Shares the multiplexed cache bus (14-bit two-phase address, 16-bit data, 3-bit ctrl) between two bus requesters, such as two matrix-multiply cores or a core plus a DMA engine.

- Accepts whole transactions from each requester over a simple valid/ready port.
- Runs the bus protocol on the requester's behalf and returns read data or a completion/timeout status.
- Sits between the requesters and the top-level tri-state buffers. The block itself has no inout ports; the top drives `bufif1` from the `*_oe` outputs.

## Interface

Parameters:
- `TIMEOUT`, default 255: maximum WAIT cycles without a slave response before the transaction is failed (range 1..1023).

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0_valid`, `req1_valid` in 1: transaction request; must be held with its payload until the matching `ready` is seen.
- `req0_cmd`, `req1_cmd` in 3: command, one of 1=READ8, 2=READ16, 3=READ32, 4=INVALIDATE, 5=WRITE8, 6=WRITE16, 7=WRITE32.
- `req0_addr`, `req1_addr` in 18: byte address; bits [17:4] are the line, bits [3:0] the offset.
- `req0_wdata`, `req1_wdata` in 32: write data; the used width depends on `cmd`.
- `req0_ready`, `req1_ready` out 1: one-cycle accept pulse.
- `resp0_valid`, `resp1_valid` out 1: one-cycle completion pulse.
- `resp0_err`, `resp1_err` out 1: meaningful only while `resp_valid` is high; 1 means timeout or illegal command.
- `resp0_rdata`, `resp1_rdata` out 32: read data, zero-extended; 0 for writes, INVALIDATE and errors.
- `bus_addr` out 14: shared address lines.
- `bus_ctrl_o` out 3: ctrl value to drive.
- `bus_ctrl_oe` out 1: ctrl driver enable.
- `bus_ctrl_i` in 3: sampled ctrl lines.
- `bus_data_o` out 16: data value to drive.
- `bus_data_oe` out 1: data driver enable.
- `bus_data_i` in 16: sampled data lines.

## Operation

- **States:** IDLE, CMD, ADDR2, TURN, WAIT, RD2, DONE.
- **Reset** (asynchronous, immediate):
  - State returns to IDLE.
  - All outputs are 0, including `bus_addr`, both `oe` signals, all `ready`, all `resp` signals and `rdata`.
  - The round-robin pointer is set so req0 wins the first tie.
  - A transaction in flight is abandoned: no `resp` is ever issued for it, and the bus is released in the same instant.
- **Arbitration (IDLE):**
  - With exactly one `valid` high, that requester is granted.
  - With both high, the requester not served last is granted.
  - `readyN` is combinational: `state==IDLE` AND grant AND `validN`.
  - On that edge the block captures `cmd`, `addr` and `wdata`, updates the pointer, and goes to CMD.
  - A requester that is not granted sees `ready=0` and keeps waiting.
  - Dropping `valid` before `ready` withdraws the request with no side effects.
- **Illegal command:** `cmd==0` is accepted and goes directly to DONE with `err=1`; there is no bus activity.
- **CMD** (1 cycle):
  - `bus_addr=addr[17:4]`, `bus_ctrl_o=cmd`, `bus_ctrl_oe=1`.
  - For writes: `bus_data_o=wdata[15:0]`, `bus_data_oe=1`.
- **ADDR2** (1 cycle):
  - `bus_addr={10'b0, addr[3:0]}`; ctrl stays driven.
  - For writes: `bus_data_o=wdata[31:16]`.
- **TURN** (1 cycle): both `oe` are 0; `bus_ctrl_i` is ignored.
- **WAIT:**
  - `bus_ctrl_i` is sampled each edge.
  - A value of 7 means slave response:
    - READ8: capture `bus_data_i[7:0]`.
    - READ16: capture `bus_data_i[15:0]`.
    - READ32: capture the low half, then go to RD2.
    - Otherwise go to DONE.
  - A wait counter increments per WAIT cycle. If it reaches `TIMEOUT` with no response, go to DONE with `err=1` and `rdata=0`.
  - A response arriving after a timeout is ignored.
- **RD2** (1 cycle): capture `bus_data_i` into `rdata[31:16]`, then go to DONE.
- **DONE** (1 cycle):
  - `resp_valid=1` to the owning requester only, with `rdata` and `err`.
  - Then return to IDLE.
  - `resp_rdata` holds its value until the next response to that requester.

## Timing

- **Transaction timeline** (T0 = the cycle `ready` is high):
  - CMD in T1, ADDR2 in T2, TURN in T3, first WAIT cycle in T4.
  - Response seen at the end of cycle Tw gives `resp_valid` in Tw+1, or Tw+2 for READ32.
  - Minimum read8, read16, write or INVALIDATE: `resp_valid` in T5.
  - Minimum READ32: `resp_valid` in T6.
- **Turnaround:** the next `ready` comes no earlier than the cycle after DONE. Back-to-back accept spacing is 6 cycles minimum.
- **Timeout:** with no response, `resp_valid` with `err=1` arrives in cycle T4+`TIMEOUT`.
- **Output registers:** `bus_addr`, `bus_ctrl_*` and `bus_data_*` are registered outputs of the state. They are never driven in IDLE, TURN, WAIT, RD2 or DONE.
- **Bus ownership:** only one requester owns the bus at a time. A `valid` arriving mid-transaction is not accepted until IDLE.

## Test plan

- **Single READ8:**
  - Stimulus: after reset, req0 READ8 at addr 0x12345; the slave drives ctrl=7 and data=0x00AB in T4.
  - Required: `bus_addr` 0x1234 in T1 and 0x0005 in T2 with ctrl=1; `resp0_valid` in T5 with `rdata` 0x000000AB and `err=0`.
- **WRITE32:**
  - Stimulus: req1 WRITE32 with `wdata` 0xDEADBEEF at addr 0x00010; slave responds in T6.
  - Required: `bus_data_o` 0xBEEF in T1 and 0xDEAD in T2 with `data_oe=1`; `oe=0` from T3; `resp1_valid` in T7.
- **READ32:**
  - Stimulus: slave drives 7 with data 0x5678, then 0x1234 on the next cycle.
  - Required: `rdata`=0x12345678, `resp_valid` two cycles after the response.
- **Arbitration:**
  - Stimulus: both requesters hold `valid` continuously from reset.
  - Required: grants alternate req0, req1, req0, …; the `ready` pulses never overlap, and each `resp` goes only to its owner.
- **Timeout:**
  - Stimulus: `TIMEOUT`=8; the slave never answers.
  - Required: `resp_valid` with `err=1` and `rdata=0` in T12; a late ctrl=7 afterwards produces no `resp`; the next request proceeds normally.
- **Reset mid-operation:**
  - Stimulus: assert `rst_n`=0 during ADDR2.
  - Required: `bus_ctrl_oe`, `bus_data_oe` and `bus_addr` are 0 immediately, with no `resp`; after release, req0 wins a tie.

Source files
------------

// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: two-requester round-robin front end that
// runs the multiplexed cache bus protocol on the winner's behalf.
module bus_master_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [2:0]  req0_cmd,
  input  logic [17:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [2:0]  req1_cmd,
  input  logic [17:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        resp0_valid,
  output logic        resp0_err,
  output logic [31:0] resp0_rdata,
  output logic        resp1_valid,
  output logic        resp1_err,
  output logic [31:0] resp1_rdata,
  output logic [13:0] bus_addr,
  output logic [2:0]  bus_ctrl_o,
  output logic        bus_ctrl_oe,
  input  logic [2:0]  bus_ctrl_i,
  output logic [15:0] bus_data_o,
  output logic        bus_data_oe,
  input  logic [15:0] bus_data_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR2, S_TURN,
    S_WAIT, S_RD2, S_DONE
  } state_t;

  state_t      state, state_n;
  logic        owner, owner_n;
  logic        last, last_n;
  logic [2:0]  cmd, cmd_n;
  logic [17:0] addr, addr_n;
  logic [31:0] wdata, wdata_n;
  logic [15:0] lo, lo_n;
  logic [9:0]  cnt, cnt_n;
  logic        err, err_n;
  logic [31:0] rdata_n;
  logic        fin;

  logic [13:0] baddr_n;
  logic [2:0]  bctrl_n;
  logic        bctrl_oe_n;
  logic [15:0] bdata_n;
  logic        bdata_oe_n;
  logic        wr_n;

  logic        any_valid;
  logic        grant1;
  logic [2:0]  sel_cmd;
  logic [17:0] sel_addr;
  logic [31:0] sel_wdata;

  // last holds the requester served most recently
  assign any_valid = req0_valid | req1_valid;
  assign grant1    = req1_valid & (~req0_valid | ~last);
  assign sel_cmd   = grant1 ? req1_cmd   : req0_cmd;
  assign sel_addr  = grant1 ? req1_addr  : req0_addr;
  assign sel_wdata = grant1 ? req1_wdata : req0_wdata;

  assign req0_ready = rst_n & (state == S_IDLE)
                    & req0_valid & ~grant1;
  assign req1_ready = rst_n & (state == S_IDLE) & grant1;

  assign resp0_valid = (state == S_DONE) & ~owner;
  assign resp1_valid = (state == S_DONE) & owner;
  assign resp0_err   = resp0_valid & err;
  assign resp1_err   = resp1_valid & err;

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    cmd_n   = cmd;
    addr_n  = addr;
    wdata_n = wdata;
    lo_n    = lo;
    cnt_n   = cnt;
    err_n   = err;
    rdata_n = '0;
    fin     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (any_valid) begin
          owner_n = grant1;
          last_n  = grant1;
          cmd_n   = sel_cmd;
          addr_n  = sel_addr;
          wdata_n = sel_wdata;
          cnt_n   = '0;
          err_n   = 1'b0;
          state_n = S_CMD;
          if (sel_cmd == 3'd0) begin
            err_n   = 1'b1;
            fin     = 1'b1;
            state_n = S_DONE;
          end
        end
      end
      S_CMD:   state_n = S_ADDR2;
      S_ADDR2: state_n = S_TURN;
      S_TURN: begin
        cnt_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (bus_ctrl_i == 3'd7) begin
          unique case (cmd)
            3'd1: begin
              rdata_n = {24'd0, bus_data_i[7:0]};
              fin     = 1'b1;
              state_n = S_DONE;
            end
            3'd2: begin
              rdata_n = {16'd0, bus_data_i};
              fin     = 1'b1;
              state_n = S_DONE;
            end
            3'd3: begin
              lo_n    = bus_data_i;
              state_n = S_RD2;
            end
            default: begin
              fin     = 1'b1;
              state_n = S_DONE;
            end
          endcase
        end else if (cnt == 10'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          fin     = 1'b1;
          state_n = S_DONE;
        end else begin
          cnt_n = cnt + 10'd1;
        end
      end
      S_RD2: begin
        rdata_n = {bus_data_i, lo};
        fin     = 1'b1;
        state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // bus drivers are registered from the next state
  assign wr_n = cmd_n[2] & (cmd_n[1] | cmd_n[0]);

  always_comb begin
    baddr_n    = '0;
    bctrl_n    = '0;
    bctrl_oe_n = 1'b0;
    bdata_n    = '0;
    bdata_oe_n = 1'b0;
    unique case (1'b1)
      (state_n == S_CMD): begin
        baddr_n    = addr_n[17:4];
        bctrl_n    = cmd_n;
        bctrl_oe_n = 1'b1;
        bdata_n    = wr_n ? wdata_n[15:0] : 16'd0;
        bdata_oe_n = wr_n;
      end
      (state_n == S_ADDR2): begin
        baddr_n    = {10'd0, addr_n[3:0]};
        bctrl_n    = cmd_n;
        bctrl_oe_n = 1'b1;
        bdata_n    = wr_n ? wdata_n[31:16] : 16'd0;
        bdata_oe_n = wr_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      last        <= 1'b1;
      cmd         <= '0;
      addr        <= '0;
      wdata       <= '0;
      lo          <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      resp0_rdata <= '0;
      resp1_rdata <= '0;
      bus_addr    <= '0;
      bus_ctrl_o  <= '0;
      bus_ctrl_oe <= 1'b0;
      bus_data_o  <= '0;
      bus_data_oe <= 1'b0;
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      last        <= last_n;
      cmd         <= cmd_n;
      addr        <= addr_n;
      wdata       <= wdata_n;
      lo          <= lo_n;
      cnt         <= cnt_n;
      err         <= err_n;
      bus_addr    <= baddr_n;
      bus_ctrl_o  <= bctrl_n;
      bus_ctrl_oe <= bctrl_oe_n;
      bus_data_o  <= bdata_n;
      bus_data_oe <= bdata_oe_n;
      if (fin && !owner_n) resp0_rdata <= rdata_n;
      if (fin && owner_n)  resp1_rdata <= rdata_n;
    end
  end

endmodule
